inv_key_sched: RTL and testbench

//  Decrypt-side AES-128 key schedule. Accepts the 128-bit cipher key and

---
 rtl/inv_key_sched.sv | 145 ++++++++++++++
 tb/tb_inv_key_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_sched.sv
// Decrypt-side AES-128 key schedule: expands the cipher key forward to round
// key 10, then walks back down to round key 0 by inverting the recurrence,
// holding only a single 128-bit key register.

// Combinational AES S-box lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Entry 0 sits in the most significant byte, so index with ~a.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table lookup.
  always_comb begin
    y = SBOX_TABLE[{~a, 3'b000} +: 8];
  end
endmodule

// State table:
//   IDLE   | waiting for a cipher key, key_ready high
//   EXPAND | one forward expansion round per cycle up to round 10
//   SERVE  | presenting round keys 10..0, one backward step per handshake
module inv_key_sched #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             flush,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_round,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy
);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

  state_t      state, state_nxt;
  logic [127:0] key_reg;
  logic [3:0]  cnt;
  logic [7:0]  rcon;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] fw0, fw1, fw2, fw3;
  logic [31:0] v0, v1, v2, v3;
  logic [31:0] sub_in, rot_w, sub_rot;
  logic [7:0]  rcon_fwd, rcon_bwd;

  assign w0 = key_reg[31:0];
  assign w1 = key_reg[63:32];
  assign w2 = key_reg[95:64];
  assign w3 = key_reg[127:96];

  // Backward step needs SubWord of the recovered w3; forward uses the current w3.
  assign v3     = w3 ^ w2;
  assign v2     = w2 ^ w1;
  assign v1     = w1 ^ w0;
  assign sub_in = (state == SERVE) ? v3 : w3;
  assign rot_w  = {sub_in[7:0], sub_in[31:8]};

  aes_sbox u_sbox0 (.a(rot_w[7:0]),   .y(sub_rot[7:0]));
  aes_sbox u_sbox1 (.a(rot_w[15:8]),  .y(sub_rot[15:8]));
  aes_sbox u_sbox2 (.a(rot_w[23:16]), .y(sub_rot[23:16]));
  aes_sbox u_sbox3 (.a(rot_w[31:24]), .y(sub_rot[31:24]));

  assign fw0 = w0 ^ sub_rot ^ {24'h0, rcon};
  assign fw1 = w1 ^ fw0;
  assign fw2 = w2 ^ fw1;
  assign fw3 = w3 ^ fw2;
  assign v0  = w0 ^ sub_rot ^ {24'h0, rcon};

  assign rcon_fwd = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign rcon_bwd = (rcon == 8'h1b) ? 8'h80 : {1'b0, rcon[7:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_valid) state_nxt = EXPAND;
      EXPAND:  if (cnt == LAST_ROUND - 4'd1) state_nxt = SERVE;
      SERVE:   if (rk_ready && cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Key register, round counter and round constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= '0;
      cnt     <= '0;
      rcon    <= 8'h01;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_reg <= key_in;
            cnt     <= '0;
            rcon    <= 8'h01;
          end
        end
        EXPAND: begin
          key_reg <= {fw3, fw2, fw1, fw0};
          cnt     <= cnt + 4'd1;
          // Hold Rcon[10] after the last forward round for the first backward step.
          if (cnt < LAST_ROUND - 4'd1) rcon <= rcon_fwd;
        end
        SERVE: begin
          if (rk_ready && cnt != 4'd0) begin
            key_reg <= {v3, v2, v1, v0};
            cnt     <= cnt - 4'd1;
            rcon    <= rcon_bwd;
          end
        end
        default: ;
      endcase
    end
  end

  assign rk_out    = key_reg;
  assign rk_round  = cnt;
  assign rk_valid  = (state == SERVE);
  assign busy      = (state != IDLE);
  assign key_ready = (state == IDLE);
endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched: golden forward expansion with a computed S-box,
// scoreboard of expected round keys popped on each rk handshake.
module tb_inv_key_sched;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         flush;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] mk [11];
  logic [131:0] sb [$];

  localparam logic [127:0] K_T1   = 128'h100f0e0d0c0b0a090807060504030201;
  localparam logic [127:0] K_T1_10 = 128'h8740b1b1656281a1735c1a6f4214c4bc;
  localparam logic [127:0] K_T1_1  = 128'hc7ca76aad7c578a7dbce72aed3c974ab;
  localparam logic [127:0] K_FIPS = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] K_FIPS_10 = 128'hc5302b4d8ba707f3174a94e37f1d1113;

  inv_key_sched dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .flush(flush), .rk_out(rk_out), .rk_round(rk_round),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from GF(2^8) inverse plus affine transform.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] b;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      if (v == 0) inv = 8'h00;
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[v] = b;
    end
  endtask

  function automatic logic [31:0] subrot(input logic [31:0] w);
    logic [31:0] r = {w[7:0], w[31:8]};
    return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  // Forward expansion of all 11 round keys into mk.
  task automatic expand_model(input logic [127:0] key);
    logic [7:0] rc = 8'h01;
    logic [31:0] w [4];
    mk[0] = key;
    for (int j = 0; j < 4; j++) w[j] = key[32*j +: 32];
    for (int r = 1; r <= 10; r++) begin
      w[0] = w[0] ^ subrot(w[3]) ^ {24'h0, rc};
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      mk[r] = {w[3], w[2], w[1], w[0]};
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
  endtask

  task automatic push_key(input logic [127:0] key);
    expand_model(key);
    for (int r = 10; r >= 0; r--) sb.push_back({4'(r), mk[r]});
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_round(input logic [3:0] r, input string tag);
    for (int i = 0; i < 40 && !(rk_valid === 1'b1 && rk_round === r); i++) tick();
    chk(tag, {123'h0, rk_valid, rk_round}, {123'h0, 1'b1, r});
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
    chk(tag, {127'h0, busy}, 128'h0);
    chk({tag, "_sb_empty"}, 128'(sb.size()), 128'h0);
  endtask

  task automatic send_key(input logic [127:0] k);
    key_in = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  // Scoreboard check on every round-key transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rk_valid === 1'b1 && rk_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", {124'h0, rk_round}, 128'h0);
      end else begin
        logic [131:0] e;
        e = sb.pop_front();
        chk("rk_round", {124'h0, rk_round}, {124'h0, e[131:128]});
        chk("rk_out", rk_out, e[127:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; key_in = '0; key_valid = 1'b0; flush = 1'b0; rk_ready = 1'b0;
    build_sbox();
    #12;
    chk("rst_key_ready", {127'h0, key_ready}, 128'h1);
    chk("rst_rk_valid", {127'h0, rk_valid}, 128'h0);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    chk("rst_rk_round", {124'h0, rk_round}, 128'h0);
    chk("rst_rk_out", rk_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: latency, spec vectors for rounds 10/1/0
    push_key(K_T1);
    sb[0][127:0] = K_T1_10;
    sb[9][127:0] = K_T1_1;
    sb[10][127:0] = K_T1;
    send_key(K_T1);
    chk("t1_busy", {127'h0, busy}, 128'h1);
    chk("t1_key_ready", {127'h0, key_ready}, 128'h0);
    for (int i = 0; i < 9; i++) tick();
    chk("t1_early_valid", {127'h0, rk_valid}, 128'h0);
    tick();
    chk("t1_valid_e10", {127'h0, rk_valid}, 128'h1);
    chk("t1_round10", {124'h0, rk_round}, 128'd10);
    chk("t1_rk10", rk_out, K_T1_10);
    rk_ready = 1'b1;
    wait_idle("t1_idle");
    chk("t1_key_ready_end", {127'h0, key_ready}, 128'h1);

    // T2: FIPS key, back-to-back delivery
    push_key(K_FIPS);
    sb[0][127:0] = K_FIPS_10;
    send_key(K_FIPS);
    wait_round(4'd10, "t2_first");
    for (int i = 0; i < 11; i++) tick();
    chk("t2_throughput_busy", {127'h0, busy}, 128'h0);
    chk("t2_sb_empty", 128'(sb.size()), 128'h0);

    // T3: backpressure at round 7
    rk_ready = 1'b0;
    push_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    send_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_round(4'd10, "t3_r10");
    rk_ready = 1'b1;
    tick(); tick(); tick();
    rk_ready = 1'b0;
    chk("t3_at7", {124'h0, rk_round}, 128'd7);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_hold_round", {124'h0, rk_round}, 128'd7);
    chk("t3_hold_key", rk_out, mk[7]);
    chk("t3_hold_valid", {127'h0, rk_valid}, 128'h1);
    rk_ready = 1'b1;
    tick();
    chk("t3_resume", {124'h0, rk_round}, 128'd6);
    wait_idle("t3_idle");

    // T4: async reset during EXPAND
    rk_ready = 1'b0;
    send_key(K_FIPS);
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", {127'h0, rk_valid}, 128'h0);
    chk("t4_rst_busy", {127'h0, busy}, 128'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t4_key_ready", {127'h0, key_ready}, 128'h1);
    rk_ready = 1'b1;
    push_key(K_T1);
    send_key(K_T1);
    wait_round(4'd10, "t4_r10");
    chk("t4_rk10", rk_out, K_T1_10);
    wait_idle("t4_idle");

    // T5: flush during handshake at round 6
    push_key(K_FIPS);
    send_key(K_FIPS);
    wait_round(4'd6, "t5_r6");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    chk("t5_valid", {127'h0, rk_valid}, 128'h0);
    chk("t5_key_ready", {127'h0, key_ready}, 128'h1);
    push_key(128'hffeeddccbbaa99887766554433221100);
    send_key(128'hffeeddccbbaa99887766554433221100);
    wait_idle("t5_idle");

    // T6: key_valid held across the round-0 handshake
    push_key(K_T1);
    send_key(K_T1);
    wait_round(4'd0, "t6_r0");
    key_in = K_FIPS;
    key_valid = 1'b1;
    push_key(K_FIPS);
    chk("t6_no_ready", {127'h0, key_ready}, 128'h0);
    tick();
    chk("t6_idle_ready", {127'h0, key_ready}, 128'h1);
    chk("t6_idle_valid", {127'h0, rk_valid}, 128'h0);
    tick();
    key_valid = 1'b0;
    chk("t6_accepted", {127'h0, busy}, 128'h1);
    for (int i = 0; i < 9; i++) tick();
    chk("t6_early", {127'h0, rk_valid}, 128'h0);
    tick();
    chk("t6_valid", {127'h0, rk_valid}, 128'h1);
    chk("t6_round10", {124'h0, rk_round}, 128'd10);
    wait_idle("t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
